// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer step encoding, ALU codes and the control word shared by the sequencer
package cpu_pkg;
   localparam logic [4:0] OP_LDW    = 5'd0;
   localparam logic [4:0] OP_LDWI   = 5'd1;
   localparam logic [4:0] OP_STW    = 5'd2;
   localparam logic [4:0] OP_ADD    = 5'd3;
   localparam logic [4:0] OP_SUB    = 5'd4;
   localparam logic [4:0] OP_SHR    = 5'd5;
   localparam logic [4:0] OP_SHL    = 5'd6;
   localparam logic [4:0] OP_ROR    = 5'd7;
   localparam logic [4:0] OP_ROL    = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_OR     = 5'd10;
   localparam logic [4:0] OP_ADDI   = 5'd11;
   localparam logic [4:0] OP_ANDI   = 5'd12;
   localparam logic [4:0] OP_ORI    = 5'd13;
   localparam logic [4:0] OP_MUL    = 5'd14;
   localparam logic [4:0] OP_DIV    = 5'd15;
   localparam logic [4:0] OP_NEG    = 5'd16;
   localparam logic [4:0] OP_NOT    = 5'd17;
   localparam logic [4:0] OP_BRANCH = 5'd18;
   localparam logic [4:0] OP_JR     = 5'd19;
   localparam logic [4:0] OP_JAL    = 5'd20;
   localparam logic [4:0] OP_IN     = 5'd21;
   localparam logic [4:0] OP_OUT    = 5'd22;
   localparam logic [4:0] OP_MFHI   = 5'd23;
   localparam logic [4:0] OP_MFLO   = 5'd24;
   localparam logic [4:0] OP_NOP    = 5'd25;
   localparam logic [4:0] OP_HALT   = 5'd26;

   // The ALU shares its operation codes with the register-form opcodes
   localparam logic [4:0] ALU_ADD = OP_ADD;
   localparam logic [4:0] ALU_AND = OP_AND;
   localparam logic [4:0] ALU_OR  = OP_OR;

   typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;

   typedef struct packed {
      logic       pc_out;
      logic       zhigh_out;
      logic       zlow_out;
      logic       mdr_out;
      logic       hi_out;
      logic       lo_out;
      logic       inport_out;
      logic       c_out;
      logic       ba_out;
      logic       r_out;
      logic       pc_en;
      logic       ir_en;
      logic       y_en;
      logic       zhigh_in;
      logic       zlow_in;
      logic       mar_en;
      logic       mdr_en;
      logic       hi_en;
      logic       lo_en;
      logic       outport_en;
      logic       con_en;
      logic       r_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       inc_pc;
      logic       mdr_read;
      logic       ram_write;
      logic [4:0] alu_op;
      logic       link_en;
      logic [3:0] link_sel;
      logic       run;
      logic       illegal;
   } ctrl_t;

   // Final execute step of each opcode; fetch steps are never final
   function automatic state_t last_step(input logic [4:0] op);
      if (op == OP_LDW || op == OP_STW) return S_T7;
      if (op == OP_MUL || op == OP_DIV || op == OP_BRANCH) return S_T6;
      if (op <= OP_ORI) return S_T5;
      if (op == OP_NEG || op == OP_NOT || op == OP_JAL) return S_T4;
      return S_T3;
   endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/status inputs and datapath control lines of the sequencer
interface control_sequencer_if;
   logic [31:0] IR;
   logic        CON_FF;
   logic        Mem_ready;
   logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out;
   logic        PC_enable, IR_enable, Y_enable, ZHighIn, ZLowIn, MAR_enable, MDR_enable;
   logic        HI_enable, LO_enable, OutPort_enable, CON_enable, R_in;
   logic        Gra, Grb, Grc, IncPC, MDR_read, RAM_write;
   logic [4:0]  ALU_op;
   logic        Link_en;
   logic [3:0]  Link_sel;
   logic        Run;
   logic        Illegal;

   modport master (
      input  IR, CON_FF, Mem_ready,
      output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
      output PC_enable, IR_enable, Y_enable, ZHighIn, ZLowIn, MAR_enable, MDR_enable,
      output HI_enable, LO_enable, OutPort_enable, CON_enable, R_in,
      output Gra, Grb, Grc, IncPC, MDR_read, RAM_write, ALU_op, Link_en, Link_sel, Run, Illegal
   );

   modport slave (
      output IR, CON_FF, Mem_ready,
      input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
      input  PC_enable, IR_enable, Y_enable, ZHighIn, ZLowIn, MAR_enable, MDR_enable,
      input  HI_enable, LO_enable, OutPort_enable, CON_enable, R_in,
      input  Gra, Grb, Grc, IncPC, MDR_read, RAM_write, ALU_op, Link_en, Link_sel, Run, Illegal
   );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: control word for the current step from the registered state, latched opcode and CON_FF
module ctrl_decode import cpu_pkg::*; #(
   parameter int         OPC_W    = 5,
   parameter logic [3:0] LINK_REG = 4'd15
) (
   input  state_t           state,
   input  logic [OPC_W-1:0] op,
   input  logic             con_ff,
   input  logic             run,
   output ctrl_t            c
);
   logic mem, rr, imm, md, nn;

   always_comb begin
      mem = op <= OP_STW;
      rr  = op >= OP_ADD && op <= OP_OR;
      imm = op >= OP_ADDI && op <= OP_ORI;
      md  = op == OP_MUL || op == OP_DIV;
      nn  = op == OP_NEG || op == OP_NOT;
      c = '0;
      if (run && state != S_HALT) begin
         c.run = 1'b1;
         c.link_sel = LINK_REG;
         case (state)
            S_T0: {c.pc_out, c.mar_en, c.inc_pc, c.zlow_in} = '1;
            S_T1: {c.zlow_out, c.pc_en, c.mdr_read, c.mdr_en} = '1;
            S_T2: {c.mdr_out, c.ir_en} = '1;
            S_T3:
               if (mem) {c.grb, c.ba_out, c.y_en} = '1;
               else if (rr || imm) {c.grb, c.r_out, c.y_en} = '1;
               else if (md) {c.gra, c.r_out, c.y_en} = '1;
               else if (nn) begin
                  {c.grb, c.r_out, c.zlow_in} = '1;
                  c.alu_op = 5'(op);
               end
               else if (op == OP_BRANCH) {c.gra, c.r_out, c.con_en} = '1;
               else if (op == OP_JR) {c.gra, c.r_out, c.pc_en} = '1;
               else if (op == OP_JAL) {c.pc_out, c.link_en, c.r_in} = '1;
               else if (op == OP_IN) {c.inport_out, c.gra, c.r_in} = '1;
               else if (op == OP_OUT) {c.gra, c.r_out, c.outport_en} = '1;
               else if (op == OP_MFHI) {c.hi_out, c.gra, c.r_in} = '1;
               else if (op == OP_MFLO) {c.lo_out, c.gra, c.r_in} = '1;
               else c.illegal = op > OP_HALT;
            S_T4:
               if (mem || imm) begin
                  {c.c_out, c.zlow_in} = '1;
                  c.alu_op = mem || op == OP_ADDI ? ALU_ADD : op == OP_ANDI ? ALU_AND : ALU_OR;
               end
               else if (rr || md) begin
                  {c.r_out, c.zlow_in} = '1;
                  c.grc = rr;
                  c.grb = md;
                  c.zhigh_in = md;
                  c.alu_op = 5'(op);
               end
               else if (nn) {c.zlow_out, c.gra, c.r_in} = '1;
               else if (op == OP_BRANCH) {c.pc_out, c.y_en} = '1;
               else if (op == OP_JAL) {c.gra, c.r_out, c.pc_en} = '1;
            S_T5:
               if (op == OP_LDW || op == OP_STW) {c.zlow_out, c.mar_en} = '1;
               else if (md) {c.zlow_out, c.lo_en} = '1;
               else if (op == OP_BRANCH) begin
                  {c.c_out, c.zlow_in} = '1;
                  c.alu_op = ALU_ADD;
               end
               else if (mem || rr || imm) {c.zlow_out, c.gra, c.r_in} = '1;
            S_T6:
               if (op == OP_LDW) {c.mdr_read, c.mdr_en} = '1;
               else if (op == OP_STW) {c.gra, c.r_out, c.mdr_en} = '1;
               else if (md) {c.zhigh_out, c.hi_en} = '1;
               else if (op == OP_BRANCH) begin
                  c.zlow_out = 1'b1;
                  c.pc_en = con_ff;
               end
            S_T7:
               if (op == OP_LDW) {c.mdr_out, c.gra, c.r_in} = '1;
               else if (op == OP_STW) {c.mdr_out, c.ram_write} = '1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer with memory-ready waits and a halt state
module control_sequencer import cpu_pkg::*; #(
   parameter int         OPC_W    = 5,
   parameter logic [3:0] LINK_REG = 4'd15
) (
   input logic                 Clock,
   input logic                 Clear,
   control_sequencer_if.master bus
);
   state_t           state_q, state_d;
   logic [OPC_W-1:0] op_q, op_d;
   logic             run_q, run_d, wait_st;
   ctrl_t            c;

   // run_q keeps outputs quiet for the first edge after Clear so T0 appears one cycle later
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      run_d = 1'b1;
      wait_st = state_q == S_T1 || (state_q == S_T6 && op_q == OP_LDW) || (state_q == S_T7 && op_q == OP_STW);
      if (run_q && state_q != S_HALT && !(wait_st && !bus.Mem_ready)) begin
         if (state_q == S_T2) op_d = bus.IR[31 -: OPC_W];
         state_d = state_q != last_step(5'(op_q)) ? state_t'(state_q + 4'd1) : op_q == OP_HALT ? S_HALT : S_T0;
      end
   end

   always_ff @(posedge Clock or negedge Clear)
      if (!Clear) begin
         state_q <= S_T0;
         op_q <= '0;
         run_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         run_q <= run_d;
      end

   ctrl_decode #(.OPC_W(OPC_W), .LINK_REG(LINK_REG)) u_decode (
      .state (state_q),
      .op    (op_q),
      .con_ff(bus.CON_FF),
      .run   (run_q),
      .c     (c)
   );

   assign {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout, bus.InPortout,
           bus.Cout, bus.BAout, bus.R_out, bus.PC_enable, bus.IR_enable, bus.Y_enable, bus.ZHighIn,
           bus.ZLowIn, bus.MAR_enable, bus.MDR_enable, bus.HI_enable, bus.LO_enable, bus.OutPort_enable,
           bus.CON_enable, bus.R_in, bus.Gra, bus.Grb, bus.Grc, bus.IncPC, bus.MDR_read, bus.RAM_write,
           bus.ALU_op, bus.Link_en, bus.Link_sel, bus.Run, bus.Illegal} = c;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle scoreboard of the expected control word for each instruction
module tb_control_sequencer;
   import cpu_pkg::*;

   typedef struct {
      ctrl_t exp;
      logic  rdy;
   } ent_t;

   logic  Clock = 1'b0;
   logic  Clear = 1'b0;
   int    n_tests = 0;
   int    n_fail = 0;
   string cur_tag = "reset";
   ent_t  sb[$];
   ctrl_t obs, last_exp;
   logic  [9:0] srcs;

   control_sequencer_if bus ();
   control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

   always #5 Clock = ~Clock;

   assign srcs = {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout,
                  bus.InPortout, bus.Cout, bus.BAout, bus.R_out};
   assign obs = {srcs, bus.PC_enable, bus.IR_enable, bus.Y_enable, bus.ZHighIn,
                 bus.ZLowIn, bus.MAR_enable, bus.MDR_enable, bus.HI_enable, bus.LO_enable, bus.OutPort_enable,
                 bus.CON_enable, bus.R_in, bus.Gra, bus.Grb, bus.Grc, bus.IncPC, bus.MDR_read, bus.RAM_write,
                 bus.ALU_op, bus.Link_en, bus.Link_sel, bus.Run, bus.Illegal};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic put(input ctrl_t e, input int w);
      repeat (w) sb.push_back('{exp: e, rdy: 1'b0});
      sb.push_back('{exp: e, rdy: 1'b1});
   endtask

   task automatic push_instr(input logic [4:0] op, input logic cf, input int w1, input int wm);
      ctrl_t b, t;
      b = '0;
      b.run = '1;
      b.link_sel = 4'd15;
      t = b; t.pc_out = '1; t.mar_en = '1; t.inc_pc = '1; t.zlow_in = '1; put(t, 0);
      t = b; t.zlow_out = '1; t.pc_en = '1; t.mdr_read = '1; t.mdr_en = '1; put(t, w1);
      t = b; t.mdr_out = '1; t.ir_en = '1; put(t, 0);
      if (op <= 5'd2) begin
         t = b; t.grb = '1; t.ba_out = '1; t.y_en = '1; put(t, 0);
         t = b; t.c_out = '1; t.alu_op = 5'd3; t.zlow_in = '1; put(t, 0);
         if (op == 5'd1) begin
            t = b; t.zlow_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
         end else begin
            t = b; t.zlow_out = '1; t.mar_en = '1; put(t, 0);
            if (op == 5'd0) begin
               t = b; t.mdr_read = '1; t.mdr_en = '1; put(t, wm);
               t = b; t.mdr_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
            end else begin
               t = b; t.gra = '1; t.r_out = '1; t.mdr_en = '1; put(t, 0);
               t = b; t.mdr_out = '1; t.ram_write = '1; put(t, wm);
            end
         end
      end else if (op <= 5'd13) begin
         t = b; t.grb = '1; t.r_out = '1; t.y_en = '1; put(t, 0);
         t = b; t.zlow_in = '1;
         if (op <= 5'd10) begin
            t.grc = '1; t.r_out = '1; t.alu_op = op;
         end else begin
            t.c_out = '1; t.alu_op = op == 5'd11 ? 5'd3 : op == 5'd12 ? 5'd9 : 5'd10;
         end
         put(t, 0);
         t = b; t.zlow_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
      end else if (op <= 5'd15) begin
         t = b; t.gra = '1; t.r_out = '1; t.y_en = '1; put(t, 0);
         t = b; t.grb = '1; t.r_out = '1; t.alu_op = op; t.zlow_in = '1; t.zhigh_in = '1; put(t, 0);
         t = b; t.zlow_out = '1; t.lo_en = '1; put(t, 0);
         t = b; t.zhigh_out = '1; t.hi_en = '1; put(t, 0);
      end else if (op <= 5'd17) begin
         t = b; t.grb = '1; t.r_out = '1; t.alu_op = op; t.zlow_in = '1; put(t, 0);
         t = b; t.zlow_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
      end else if (op == 5'd18) begin
         t = b; t.gra = '1; t.r_out = '1; t.con_en = '1; put(t, 0);
         t = b; t.pc_out = '1; t.y_en = '1; put(t, 0);
         t = b; t.c_out = '1; t.alu_op = 5'd3; t.zlow_in = '1; put(t, 0);
         t = b; t.zlow_out = '1; t.pc_en = cf; put(t, 0);
      end else if (op == 5'd19) begin
         t = b; t.gra = '1; t.r_out = '1; t.pc_en = '1; put(t, 0);
      end else if (op == 5'd20) begin
         t = b; t.pc_out = '1; t.link_en = '1; t.r_in = '1; put(t, 0);
         t = b; t.gra = '1; t.r_out = '1; t.pc_en = '1; put(t, 0);
      end else if (op == 5'd21) begin
         t = b; t.inport_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
      end else if (op == 5'd22) begin
         t = b; t.gra = '1; t.r_out = '1; t.outport_en = '1; put(t, 0);
      end else if (op == 5'd23) begin
         t = b; t.hi_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
      end else if (op == 5'd24) begin
         t = b; t.lo_out = '1; t.gra = '1; t.r_in = '1; put(t, 0);
      end else if (op == 5'd25) begin
         put(b, 0);
      end else if (op == 5'd26) begin
         put(b, 0);
         repeat (20) put('0, 0);
      end else begin
         t = b; t.illegal = '1; put(t, 0);
      end
   endtask

   task automatic drain();
      ent_t e;
      while (sb.size() > 0) begin
         @(negedge Clock);
         e = sb.pop_front();
         check(cur_tag, 64'(obs), 64'(e.exp));
         check({cur_tag, "_src"}, 64'($countones(srcs) <= 1), 64'd1);
         bus.Mem_ready = e.rdy;
         last_exp = e.exp;
      end
   endtask

   task automatic run(input string tag, input logic [4:0] op, input logic cf, input int w1, input int wm);
      cur_tag = tag;
      bus.IR = {op, 27'($urandom)};
      bus.CON_FF = cf;
      push_instr(op, cf, w1, wm);
      drain();
   endtask

   initial begin
      bus.IR = 32'h0880_0007;
      bus.CON_FF = 1'b0;
      bus.Mem_ready = 1'b1;
      repeat (2) @(negedge Clock);
      check("reset", 64'(obs), 64'd0);
      Clear = 1'b1;
      #1 check("run_pre", 64'(bus.Run), 64'd0);
      cur_tag = "ldwi";
      push_instr(5'd1, 1'b0, 0, 0);
      drain();
      run("stw_wait", 5'd2, 1'b0, 1, 3);
      run("br_nt", 5'd18, 1'b0, 0, 0);
      run("br_t", 5'd18, 1'b1, 0, 0);
      run("mul", 5'd14, 1'b0, 0, 0);
      for (int i = 0; i < 32; i++)
         if (i != 26) run($sformatf("op%0d", i), 5'(i), 1'(i), i % 3, i % 4);
      run("halt", 5'd26, 1'b0, 0, 0);
      Clear = 1'b0;
      #1 check("halt_clr", 64'(obs), 64'd0);
      @(negedge Clock);
      Clear = 1'b1;
      run("restart", 5'd25, 1'b0, 0, 0);
      cur_tag = "ldw_abort";
      bus.IR = {5'd0, 27'd5};
      push_instr(5'd0, 1'b0, 0, 2);
      sb.delete(sb.size() - 1);
      sb.delete(sb.size() - 1);
      drain();
      #2 check("t6_hold", 64'(obs), 64'(last_exp));
      Clear = 1'b0;
      #1 check("async_clr", 64'(obs), 64'd0);
      @(negedge Clock);
      Clear = 1'b1;
      run("after_abort", 5'd1, 1'b0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
